// File: rtl/logic_unit_arbiter.sv
// Round-robin shared 32-bit bitwise logic unit for two requesters with a valid/ack result port.
// Define LOGIC_EXT_EN to enable XOR (op 10) and NOR (op 11); otherwise those opcodes return 0 with res_err set.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_err,
  input  logic             res_ack,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic             cur_id_q, cur_id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic             res_err_q, res_err_d;

  logic             winner;
  logic [WIDTH-1:0] f_res;
  logic             f_err;

  // On a tie the requester that did not win last time takes the grant.
  assign winner = (req0 && req1) ? ~last_id_q : req1;

  always_comb begin
    f_res = '0;
    f_err = 1'b0;
    case (op_q)
      2'b00: f_res = a_q & b_q;
      2'b01: f_res = a_q | b_q;
`ifdef LOGIC_EXT_EN
      2'b10: f_res = a_q ^ b_q;
      default: f_res = ~(a_q | b_q);
`else
      default: f_err = 1'b1;
`endif
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    cur_id_d    = cur_id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          cur_id_d  = winner;
          last_id_d = winner;
          op_d      = winner ? op1 : op0;
          a_d       = winner ? a1 : a0;
          b_d       = winner ? b1 : b0;
          gnt0_d    = ~winner;
          gnt1_d    = winner;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d       = f_res;
        res_err_d   = f_err;
        res_id_d    = cur_id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      cur_id_q    <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      cur_id_q    <= cur_id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter; expected values are hand-computed.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, res_ack;
  logic [1:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, res_valid, res_id, res_err, busy;
  logic [31:0] res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .res(res), .res_valid(res_valid), .res_id(res_id), .res_err(res_err),
    .res_ack(res_ack), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single requester-0 op with ack held high; b0 is changed right after the grant edge.
  task automatic op_req0(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] b_late,
                         input logic [31:0] exp_res, input logic exp_err);
    req0 = 1'b1; op0 = op; a0 = a; b0 = b; res_ack = 1'b1;
    tick;
    chk({tag, "_gnt0"}, {31'b0, gnt0}, 32'd1);
    req0 = 1'b0; b0 = b_late;
    tick;
    chk({tag, "_vld"}, {31'b0, res_valid}, 32'd1);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_err"}, {31'b0, res_err}, {31'b0, exp_err});
    tick;
    chk({tag, "_done"}, {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] exp_r;
  logic        exp_e;

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; res_ack = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick; tick;
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_vld", {31'b0, res_valid}, 32'd0);
    chk("rst_id", {31'b0, res_id}, 32'd0);
    chk("rst_err", {31'b0, res_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    // Basic AND with ack held high
    req0 = 1; op0 = 2'b00; a0 = 32'h0000A5A5; b0 = 32'h00005A5A; res_ack = 1;
    tick;
    chk("and_gnt0", {31'b0, gnt0}, 32'd1);
    chk("and_busy", {31'b0, busy}, 32'd1);
    chk("and_vld_early", {31'b0, res_valid}, 32'd0);
    req0 = 0;
    tick;
    chk("and_gnt0_pulse", {31'b0, gnt0}, 32'd0);
    chk("and_vld", {31'b0, res_valid}, 32'd1);
    chk("and_res", res, 32'h00000000);
    chk("and_id", {31'b0, res_id}, 32'd0);
    tick;
    chk("and_vld_clr", {31'b0, res_valid}, 32'd0);
    chk("and_idle", {31'b0, busy}, 32'd0);

    // Fresh reset so requester 0 wins the first tie, then check alternation
    reset = 1; tick; reset = 0;
    req0 = 1; op0 = 2'b01; a0 = 32'h0000A5A5; b0 = 32'h00005A5A;
    req1 = 1; op1 = 2'b00; a1 = 32'h00005A5A; b1 = 32'h00005A5A;
    res_ack = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("rr%0d_gnt0", i), {31'b0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_gnt1", i), {31'b0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick;
      chk($sformatf("rr%0d_id", i), {31'b0, res_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_res", i), res, (i % 2 == 0) ? 32'h0000FFFF : 32'h00005A5A);
      tick;
      if (i == 3) begin
        req0 = 0; req1 = 0;
      end
      chk($sformatf("rr%0d_clr", i), {31'b0, res_valid}, 32'd0);
    end

    // Ack held off in RESP while requester 1 waits
    res_ack = 0; req0 = 1; op0 = 2'b01; a0 = 32'h000000F0; b0 = 32'h0000000F;
    tick;
    chk("hold_gnt0", {31'b0, gnt0}, 32'd1);
    req0 = 0;
    tick;
    req1 = 1; op1 = 2'b00; a1 = 32'h00005A5A; b1 = 32'h0000FFFF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_vld", i), {31'b0, res_valid}, 32'd1);
      chk($sformatf("hold%0d_res", i), res, 32'h000000FF);
      chk($sformatf("hold%0d_gnt1", i), {31'b0, gnt1}, 32'd0);
      tick;
    end
    res_ack = 1;
    tick;
    chk("hold_ack_vld", {31'b0, res_valid}, 32'd0);
    chk("hold_ack_gnt1", {31'b0, gnt1}, 32'd0);
    chk("hold_res_kept", res, 32'h000000FF);
    tick;
    chk("hold_gnt1_late", {31'b0, gnt1}, 32'd1);
    req1 = 0;
    tick;
    chk("hold_r1_res", res, 32'h00005A5A);
    chk("hold_r1_id", {31'b0, res_id}, 32'd1);
    tick;

    // Reset during EXEC discards the op
    req0 = 1; op0 = 2'b01; a0 = 32'hFFFFFFFF; b0 = 32'h0; res_ack = 1;
    tick;
    chk("rexec_gnt0", {31'b0, gnt0}, 32'd1);
    req0 = 0; reset = 1;
    tick;
    reset = 0;
    chk("rexec_busy", {31'b0, busy}, 32'd0);
    chk("rexec_vld", {31'b0, res_valid}, 32'd0);
    chk("rexec_res", res, 32'd0);
    tick; tick;
    chk("rexec_stale_vld", {31'b0, res_valid}, 32'd0);
    chk("rexec_stale_res", res, 32'd0);

    // Extended opcodes and late operand changes
`ifdef LOGIC_EXT_EN
    exp_r = 32'hF0F00F0F; exp_e = 1'b0;
`else
    exp_r = 32'h00000000; exp_e = 1'b1;
`endif
    op_req0("xor", 2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'h12345678, exp_r, exp_e);
`ifdef LOGIC_EXT_EN
    exp_r = 32'h0F0F0000; exp_e = 1'b0;
`else
    exp_r = 32'h00000000; exp_e = 1'b1;
`endif
    op_req0("nor", 2'b11, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0, exp_r, exp_e);
    op_req0("late_b", 2'b01, 32'h000000F0, 32'h0000000F, 32'hFFFFFFFF, 32'h000000FF, 1'b0);
    op_req0("and_full", 2'b00, 32'hFFFFFFFF, 32'h80000001, 32'h0, 32'h80000001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
